core_mem_arbiter: RTL

Shares one single-port memory model between the core's instruction-fetch and data ports. All ports use the req/gnt/rvalid protocol. Arbitrates requests and forwards the winner to the memory port. Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it. Sits between the core's memory interfaces and the testbench memory, so one memory model can serve both ports.

---
 rtl/core_mem_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//   Shares one single-port memory between the core's instruction-fetch port
//   and data port. Requests are arbitrated combinationally and the winner is
//   forwarded to the memory port. Each grant pushes the winner's ID into an
//   in-order FIFO, and each memory response pops the FIFO and is routed back
//   to the port that issued it.
//
//   Optional feature macro: MEM_ARB_RR_EN
//     defined   : round-robin on contention (pointer starts at instr)
//     undefined : fixed priority, data wins on contention
//
//   Ports
//     clk_i, rst_ni          clock (rising edge), async active-low reset
//     instr_*                fetch port   (req/addr -> gnt/rvalid/rdata)
//     data_*                 data port    (req/we/be/addr/wdata -> gnt/rvalid/rdata)
//     mem_*                  memory port  (req/we/be/addr/wdata <- gnt/rvalid/rdata)
//     outstanding_o          number of granted transactions awaiting rvalid
//     resp_err_o             sticky: rvalid arrived with nothing outstanding
//
//   Handshake: a port's request must stay stable until its gnt is seen. A
//   transaction is granted in the cycle where req and gnt are both high; its
//   response (rvalid) may come no earlier than the following cycle, and
//   responses return in grant order.
module core_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               instr_req_i,
    input  logic [ADDR_WIDTH-1:0]              instr_addr_i,
    output logic                               instr_gnt_o,
    output logic                               instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]              instr_rdata_o,
    input  logic                               data_req_i,
    input  logic                               data_we_i,
    input  logic [DATA_WIDTH/8-1:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0]              data_addr_i,
    input  logic [DATA_WIDTH-1:0]              data_wdata_i,
    output logic                               data_gnt_o,
    output logic                               data_rvalid_o,
    output logic [DATA_WIDTH-1:0]              data_rdata_o,
    output logic                               mem_req_o,
    input  logic                               mem_gnt_i,
    output logic                               mem_we_o,
    output logic [DATA_WIDTH/8-1:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [DATA_WIDTH-1:0]              mem_wdata_o,
    input  logic                               mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                               resp_err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // ID encoding: 0 = instr, 1 = data
    logic                 ids_q [MAX_OUTSTANDING];
    logic                 ids_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;
    logic                 lock_q, lock_d;
    logic                 lock_id_q, lock_id_d;
    logic                 rr_q, rr_d;

    logic full, empty, any_req, both_req, winner, req, grant, pop, head;

    always_comb begin
        full     = (count_q == CNT_MAX);
        empty    = (count_q == '0);
        any_req  = instr_req_i | data_req_i;
        both_req = instr_req_i & data_req_i;

        winner = 1'b0;
        if (lock_q)           winner = lock_id_q;
        else if (!both_req)   winner = data_req_i;
`ifdef MEM_ARB_RR_EN
        else                  winner = rr_q;
`else
        else                  winner = 1'b1;
`endif

        req   = any_req & ~full;
        grant = req & mem_gnt_i;
        pop   = mem_rvalid_i & ~empty;
        head  = ids_q[rd_ptr_q];
    end

    // Next-state for FIFO, lock, error flag and round-robin pointer.
    always_comb begin
        ids_d     = ids_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = err_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_d      = rr_q;

        if (grant) begin
            ids_d[wr_ptr_q] = winner;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (grant && !pop)      count_d = count_q + 1'b1;
        else if (!grant && pop) count_d = count_q - 1'b1;

        // Emptiness is judged before this cycle's push: a same-cycle grant
        // cannot be answered by the same-cycle rvalid.
        if (mem_rvalid_i && empty) err_d = 1'b1;

        // Blocked request keeps its winner until granted; a full FIFO
        // (req low) leaves the lock untouched.
        if (req && !mem_gnt_i) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end else if (grant) begin
            lock_d    = 1'b0;
        end

`ifdef MEM_ARB_RR_EN
        if (grant && both_req && (winner == rr_q)) rr_d = ~rr_q;
`else
        rr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) ids_q[i] <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            ids_q     <= ids_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
        end
    end

    // Outputs are forced low while reset is asserted, including the
    // combinational paths, so nothing leaks through during reset.
    always_comb begin
        mem_req_o      = rst_ni & req;
        mem_we_o       = rst_ni & winner & data_we_i;
        mem_be_o       = !rst_ni ? '0 : (winner ? data_be_i : {BE_W{1'b1}});
        mem_addr_o     = !rst_ni ? '0 : (winner ? data_addr_i : instr_addr_i);
        mem_wdata_o    = (!rst_ni || !winner) ? '0 : data_wdata_i;
        instr_gnt_o    = rst_ni & grant & ~winner;
        data_gnt_o     = rst_ni & grant & winner;
        instr_rvalid_o = rst_ni & pop & ~head;
        data_rvalid_o  = rst_ni & pop & head;
        instr_rdata_o  = rst_ni ? mem_rdata_i : '0;
        data_rdata_o   = rst_ni ? mem_rdata_i : '0;
        outstanding_o  = count_q;
        resp_err_o     = err_q;
    end

endmodule
